// File: rtl/vga_pixel_fetch.sv
// Pixel-fetch stage: maps VGA pixel counters to an 8x8-cell colour buffer and drives
// re-aligned RGB/HS/VS pins; includes a cell write port and a whole-buffer clear engine.
module vga_pixel_fetch #(
  parameter int unsigned CELL_SHIFT  = 3,
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 60,
  parameter logic [2:0]  CLEAR_COLOR = 3'b000,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPixelEn,
  input  logic [9:0] iHCount,
  input  logic [9:0] iVCount,
  input  logic       iHSync,
  input  logic       iVSync,
  input  logic       iVideoOn,
  input  logic       iWrValid,
  input  logic [6:0] iWrCol,
  input  logic [5:0] iWrRow,
  input  logic [2:0] iWrColor,
  output logic       oWrReady,
  input  logic       iClear,
  output logic       oBusy,
  output logic       VGA_RED,
  output logic       VGA_GREEN,
  output logic       VGA_BLUE,
  output logic       VGA_HS,
  output logic       VGA_VS
);

  localparam int unsigned DEPTH = COLS * ROWS;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_clr_addr;
  logic            r_wr_ready;
  logic            r_busy;
  logic [2:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_rd_addr;
  logic            r_hs0;
  logic            r_vs0;
  logic            r_von0;
  logic [2:0]      r_rgb;
  logic            r_hs;
  logic            r_vs;

  logic [9:0]      w_col;
  logic [9:0]      w_row;
  logic [AW-1:0]   w_rd_addr;
  logic [AW-1:0]   w_wr_addr;
  logic            w_wr_in_range;
  logic            w_we;
  logic [AW-1:0]   w_we_addr;
  logic [2:0]      w_we_data;

  assign w_col         = iHCount >> CELL_SHIFT;
  assign w_row         = iVCount >> CELL_SHIFT;
  assign w_rd_addr     = AW'(32'(w_row) * COLS + 32'(w_col));
  assign w_wr_in_range = (32'(iWrCol) < COLS) && (32'(iWrRow) < ROWS);
  assign w_wr_addr     = AW'(32'(iWrRow) * COLS + 32'(iWrCol));

  // Single buffer write port: clear engine owns it while clearing, never written under Reset
  always_comb begin
    w_we      = 1'b0;
    w_we_addr = '0;
    w_we_data = 3'b000;
    if (!Reset) begin
      if (r_state == CLEAR) begin
        w_we      = 1'b1;
        w_we_addr = r_clr_addr;
        w_we_data = CLEAR_COLOR;
      end else if (iWrValid && r_wr_ready && w_wr_in_range) begin
        w_we      = 1'b1;
        w_we_addr = w_wr_addr;
        w_we_data = iWrColor;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (w_we) begin
      r_mem[w_we_addr] <= w_we_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_clr_addr <= '0;
      r_wr_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else if (r_state == IDLE) begin
      if (iClear) begin
        r_state    <= CLEAR;
        r_clr_addr <= '0;
        r_wr_ready <= 1'b0;
        r_busy     <= 1'b1;
      end
    end else begin
      if (r_clr_addr == AW'(DEPTH - 1)) begin
        r_state    <= IDLE;
        r_wr_ready <= 1'b1;
        r_busy     <= 1'b0;
      end else begin
        r_clr_addr <= r_clr_addr + AW'(1);
      end
    end
  end

  // Two-strobe read pipeline; the buffer read register doubles as the pin register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rd_addr <= '0;
      r_hs0     <= ~SYNC_ACTIVE;
      r_vs0     <= ~SYNC_ACTIVE;
      r_von0    <= 1'b0;
      r_rgb     <= 3'b000;
      r_hs      <= ~SYNC_ACTIVE;
      r_vs      <= ~SYNC_ACTIVE;
    end else if (iPixelEn) begin
      r_rd_addr <= w_rd_addr;
      r_hs0     <= iHSync;
      r_vs0     <= iVSync;
      r_von0    <= iVideoOn;
      r_rgb     <= r_von0 ? r_mem[r_rd_addr] : 3'b000;
      r_hs      <= r_hs0;
      r_vs      <= r_vs0;
    end
  end

  assign oWrReady  = r_wr_ready;
  assign oBusy     = r_busy;
  assign VGA_RED   = r_rgb[2];
  assign VGA_GREEN = r_rgb[1];
  assign VGA_BLUE  = r_rgb[0];
  assign VGA_HS    = r_hs;
  assign VGA_VS    = r_vs;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed + randomized bench for vga_pixel_fetch against a cell-array reference model.
module tb_vga_pixel_fetch;

  localparam int NCOLS = 80;
  localparam int NROWS = 60;
  localparam int CELL  = 8;

  typedef struct packed {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  logic       Clock;
  logic       Reset;
  logic       iPixelEn;
  logic [9:0] iHCount;
  logic [9:0] iVCount;
  logic       iHSync;
  logic       iVSync;
  logic       iVideoOn;
  logic       iWrValid;
  logic [6:0] iWrCol;
  logic [5:0] iWrRow;
  logic [2:0] iWrColor;
  logic       oWrReady;
  logic       iClear;
  logic       oBusy;
  logic       VGA_RED;
  logic       VGA_GREEN;
  logic       VGA_BLUE;
  logic       VGA_HS;
  logic       VGA_VS;

  vga_pixel_fetch dut (
    .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn),
    .iHCount(iHCount), .iVCount(iVCount), .iHSync(iHSync), .iVSync(iVSync),
    .iVideoOn(iVideoOn), .iWrValid(iWrValid), .iWrCol(iWrCol), .iWrRow(iWrRow),
    .iWrColor(iWrColor), .oWrReady(oWrReady), .iClear(iClear), .oBusy(oBusy),
    .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [2:0] model_mem [NCOLS*NROWS];
  exp_t       exp_q [$];
  exp_t       last_exp;
  int         total;
  int         bad;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [4:0] pins();
    return {VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HS, VGA_VS};
  endfunction

  // One pixel strobe; pins show the pixel presented one strobe earlier (two-strobe latency)
  task automatic strobe(input int h, input int v, input logic hs, input logic vs, input logic von);
    exp_t e;
    int   idx;
    iHCount  = 10'(h);
    iVCount  = 10'(v);
    iHSync   = hs;
    iVSync   = vs;
    iVideoOn = von;
    iPixelEn = 1'b1;
    idx      = (v / CELL) * NCOLS + (h / CELL);
    e.rgb    = (von && (h / CELL) < NCOLS && (v / CELL) < NROWS) ? model_mem[idx] : 3'b000;
    e.hs     = hs;
    e.vs     = vs;
    exp_q.push_back(e);
    tick();
    iPixelEn = 1'b0;
    if (exp_q.size() >= 2) begin
      last_exp = exp_q.pop_front();
      chk("pixel", 32'(pins()), 32'(last_exp));
    end
  endtask

  task automatic drain();
    strobe(0, 0, 1'b1, 1'b1, 1'b0);
    exp_q.delete();
  endtask

  task automatic read_cell(input int col, input int row, input logic von);
    strobe(col * CELL + int'($urandom_range(0, 7)), row * CELL + int'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), von);
  endtask

  task automatic write_cell(input int col, input int row, input logic [2:0] color);
    int n;
    iWrValid = 1'b1;
    iWrCol   = 7'(col);
    iWrRow   = 6'(row);
    iWrColor = color;
    n = 0;
    while (!oWrReady && n < 10000) begin
      tick();
      n++;
    end
    chk("wr_ready", 32'(oWrReady), 32'd1);
    tick();
    iWrValid = 1'b0;
    if (col < NCOLS && row < NROWS) model_mem[row * NCOLS + col] = color;
  endtask

  initial begin
    int n;
    int viol;
    total    = 0;
    bad      = 0;
    Reset    = 1'b1;
    iPixelEn = 1'b0;
    iHCount  = '0;
    iVCount  = '0;
    iHSync   = 1'b1;
    iVSync   = 1'b1;
    iVideoOn = 1'b0;
    iWrValid = 1'b0;
    iWrCol   = '0;
    iWrRow   = '0;
    iWrColor = '0;
    iClear   = 1'b0;
    last_exp = {3'b000, 1'b1, 1'b1};
    tick();
    tick();
    chk("rst_pins", 32'(pins()), 32'(last_exp));
    chk("rst_ready", 32'(oWrReady), 32'd1);
    chk("rst_busy", 32'(oBusy), 32'd0);
    Reset = 1'b0;

    // Pixel strobe low: pins frozen whatever the counters do
    for (int i = 0; i < 6; i++) begin
      iHCount  = 10'($urandom_range(0, 639));
      iVCount  = 10'($urandom_range(0, 479));
      iHSync   = 1'($urandom);
      iVSync   = 1'($urandom);
      iVideoOn = 1'b1;
      tick();
      chk("frozen", 32'(pins()), 32'(last_exp));
    end
    chk("idle_ready", 32'(oWrReady), 32'd1);

    // Clear with a simultaneous write; a repeated iClear mid-clear must be ignored
    iClear   = 1'b1;
    iWrValid = 1'b1;
    iWrCol   = 7'd0;
    iWrRow   = 6'd0;
    iWrColor = 3'b111;
    tick();
    iClear   = 1'b0;
    iWrValid = 1'b0;
    chk("clr_busy_start", 32'(oBusy), 32'd1);
    chk("clr_ready_start", 32'(oWrReady), 32'd0);
    n = 0;
    viol = 0;
    while (oBusy && n < 6000) begin
      if (n == 10) iClear = 1'b1;
      tick();
      iClear = 1'b0;
      n++;
      if (oBusy == oWrReady) viol++;
    end
    chk("clr_len", 32'(n), 32'd4800);
    chk("clr_mutex", 32'(viol), 32'd0);
    chk("clr_ready_end", 32'(oWrReady), 32'd1);
    for (int a = 0; a < NCOLS * NROWS; a++) model_mem[a] = 3'b000;
    read_cell(0, 0, 1'b1);
    read_cell(79, 59, 1'b1);
    for (int i = 0; i < 10; i++)
      read_cell(int'($urandom_range(0, 79)), int'($urandom_range(0, 59)), 1'b1);
    drain();

    // Painted cell (5,2) across its 8 pixels, neighbours keep old value
    write_cell(5, 2, 3'b101);
    for (int h = 39; h <= 48; h++) strobe(h, 16, 1'($urandom), 1'($urandom), 1'b1);
    strobe(42, 16, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) strobe(40 + i % 8, 17, 1'(i % 2), 1'($urandom), 1'b1);
    drain();

    // Write at the S0 edge is seen; write at the S1 edge returns old data
    iWrValid = 1'b1;
    iWrCol   = 7'd10;
    iWrRow   = 6'd3;
    iWrColor = 3'b110;
    model_mem[3 * NCOLS + 10] = 3'b110;
    strobe(82, 25, 1'b1, 1'b0, 1'b1);
    iWrValid = 1'b0;
    strobe(90, 25, 1'b0, 1'b1, 1'b1);
    iWrValid = 1'b1;
    iWrCol   = 7'd11;
    iWrColor = 3'b011;
    model_mem[3 * NCOLS + 11] = 3'b011;
    strobe(91, 26, 1'b1, 1'b1, 1'b1);
    iWrValid = 1'b0;
    strobe(300, 200, 1'b0, 1'b0, 1'b1);
    drain();

    // Out-of-range writes are accepted and dropped
    write_cell(0, 0, 3'b010);
    write_cell(79, 59, 3'b100);
    write_cell(0, 1, 3'b110);
    write_cell(80, 0, 3'b111);
    chk("oor_ready", 32'(oWrReady), 32'd1);
    write_cell(0, 60, 3'b111);
    write_cell(127, 63, 3'b111);
    write_cell(79, 60, 3'b111);
    read_cell(0, 0, 1'b1);
    read_cell(79, 59, 1'b1);
    read_cell(0, 1, 1'b1);
    read_cell(79, 58, 1'b1);
    drain();

    // Random writes and random scanning
    for (int i = 0; i < 60; i++)
      write_cell(int'($urandom_range(0, 84)), int'($urandom_range(0, 62)), 3'($urandom));
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      strobe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) != 0));
    end
    drain();

    // Reset 100 clocks into a clear
    write_cell(50, 0, 3'b101);
    write_cell(20, 1, 3'b110);
    write_cell(30, 1, 3'b011);
    write_cell(40, 30, 3'b001);
    write_cell(79, 59, 3'b100);
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    chk("clr2_busy", 32'(oBusy), 32'd1);
    repeat (100) tick();
    Reset = 1'b1;
    tick();
    chk("abort_busy", 32'(oBusy), 32'd0);
    chk("abort_ready", 32'(oWrReady), 32'd1);
    Reset = 1'b0;
    exp_q.delete();
    for (int a = 0; a < 100; a++) model_mem[a] = 3'b000;
    read_cell(50, 0, 1'b1);
    read_cell(20, 1, 1'b1);
    read_cell(30, 1, 1'b1);
    read_cell(40, 30, 1'b1);
    read_cell(79, 59, 1'b1);
    for (int i = 0; i < 15; i++)
      read_cell(int'($urandom_range(0, 79)), int'($urandom_range(0, 59)), 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
